// File: rtl/ifm_pkg.sv
// Shared types and constants for the IFM streaming controller.
// Holds the controller FSM encoding and the pipeline/kernel geometry.
package ifm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      DONE
   } state_e;

   localparam int KSIZE      = 3;
   localparam int MEM_RD_LAT = 1;
   localparam int DRAIN_CYC  = 2;

   // A frame needs at least one full window per row and at least one row.
   function automatic logic cfg_valid(input int w, input int h);
      return (w >= KSIZE) && (h != 0);
   endfunction

endpackage

// File: rtl/ifm_stream_ctrl_if.sv
// Host/SRAM/PE-facing signal bundle of the IFM streaming controller.
interface ifm_stream_ctrl_if #(
   parameter int ADDR_W = 12,
   parameter int DIM_W  = 8
);
   logic              start;
   logic [DIM_W-1:0]  img_w;
   logic [DIM_W-1:0]  img_h;
   logic [ADDR_W-1:0] base_addr;
   logic              pe_ready;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic              ifm_read;
   logic              win_valid;
   logic [DIM_W-1:0]  win_col;
   logic [DIM_W-1:0]  win_row;
   logic              busy;
   logic              done;
   logic              cfg_err;

   modport slave (
      input  start, img_w, img_h, base_addr, pe_ready,
      output mem_rd_en, mem_addr, ifm_read, win_valid, win_col, win_row, busy, done, cfg_err
   );

   modport master (
      output start, img_w, img_h, base_addr, pe_ready,
      input  mem_rd_en, mem_addr, ifm_read, win_valid, win_col, win_row, busy, done, cfg_err
   );
endinterface

// File: rtl/ifm_addr_gen.sv
// Row/column counters and linear SRAM address for the IFM fetch sequence.
// Frame geometry is captured on load; the address runs linearly across rows.
module ifm_addr_gen
   import ifm_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DIM_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic              next_row,
   input  logic [DIM_W-1:0]  img_w,
   input  logic [DIM_W-1:0]  img_h,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [DIM_W-1:0]  row,
   output logic [DIM_W-1:0]  col,
   output logic [ADDR_W-1:0] addr,
   output logic              last_col,
   output logic              last_row
);
   logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
   logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   always_comb begin
      w_d    = w_q;
      h_d    = h_q;
      row_d  = row_q;
      col_d  = col_q;
      addr_d = addr_q;
      if (load) begin
         w_d    = img_w;
         h_d    = img_h;
         row_d  = '0;
         col_d  = '0;
         addr_d = base_addr;
      end else begin
         // addr wraps naturally at 2^ADDR_W
         if (step) begin
            col_d  = col_q + 1'b1;
            addr_d = addr_q + 1'b1;
         end
         if (next_row) begin
            row_d = row_q + 1'b1;
            col_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q    <= '0;
         h_q    <= '0;
         row_q  <= '0;
         col_q  <= '0;
         addr_q <= '0;
      end else begin
         w_q    <= w_d;
         h_q    <= h_d;
         row_q  <= row_d;
         col_q  <= col_d;
         addr_q <= addr_d;
      end
   end

   assign row      = row_q;
   assign col      = col_q;
   assign addr     = addr_q;
   assign last_col = (col_q == w_q - 1'b1);
   assign last_row = (row_q == h_q - 1'b1);

endmodule

// File: rtl/ifm_stream_ctrl.sv
// Sequences IFM SRAM reads into the 3-tap shift buffer and flags complete
// windows to the PE; one row at a time with a fixed drain gap between rows.
module ifm_stream_ctrl
   import ifm_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DIM_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   ifm_stream_ctrl_if.slave bus
);
   localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYC - 1);
   localparam logic [1:0] LOAD_SAT   = 2'(KSIZE - 1);

   state_e            state_q, state_d;
   logic [1:0]        drain_cnt_q, drain_cnt_d;
   logic              err_q, err_d;
   logic              load, step, next_row, mem_rd_en, cfg_ok;
   logic [DIM_W-1:0]  row, col;
   logic [ADDR_W-1:0] addr;
   logic              last_col, last_row;

   logic              ifm_read_q, ifm_read_d;
   logic [DIM_W-1:0]  rd_col_q, rd_col_d, rd_row_q, rd_row_d;
   logic [1:0]        load_cnt_q, load_cnt_d;
   logic              win_hit;
   logic              win_valid_q, win_valid_d;
   logic [DIM_W-1:0]  win_col_q, win_col_d, win_row_q, win_row_d;
   logic              done_q, done_d, cfg_err_q, cfg_err_d;

   assign cfg_ok = cfg_valid(int'(bus.img_w), int'(bus.img_h));

   ifm_addr_gen #(
      .ADDR_W (ADDR_W),
      .DIM_W  (DIM_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .step      (step),
      .next_row  (next_row),
      .img_w     (bus.img_w),
      .img_h     (bus.img_h),
      .base_addr (bus.base_addr),
      .row       (row),
      .col       (col),
      .addr      (addr),
      .last_col  (last_col),
      .last_row  (last_row)
   );

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      err_d       = err_q;
      load        = 1'b0;
      step        = 1'b0;
      next_row    = 1'b0;
      mem_rd_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               err_d   = !cfg_ok;
               state_d = cfg_ok ? FETCH : DONE;
            end
         end
         FETCH: begin
            if (bus.pe_ready) begin
               mem_rd_en = 1'b1;
               step      = 1'b1;
               if (last_col) begin
                  state_d     = DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         DRAIN: begin
            // Fixed gap lets the last samples of the row clear the buffer pipeline.
            if (drain_cnt_q == DRAIN_LAST) begin
               drain_cnt_d = '0;
               if (last_row) begin
                  state_d = DONE;
               end else begin
                  next_row = 1'b1;
                  state_d  = FETCH;
               end
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ifm_read_d = mem_rd_en;
      rd_col_d   = rd_col_q;
      rd_row_d   = rd_row_q;
      if (mem_rd_en) begin
         rd_col_d = col;
         rd_row_d = row;
      end
      // load_cnt counts earlier samples of this row, saturating at KSIZE-1;
      // older buffer taps hold stale data from the previous row until then.
      win_hit    = ifm_read_q && (load_cnt_q == LOAD_SAT);
      load_cnt_d = load_cnt_q;
      if (load || next_row) begin
         load_cnt_d = '0;
      end else if (ifm_read_q && !win_hit) begin
         load_cnt_d = load_cnt_q + 1'b1;
      end
      win_valid_d = win_hit;
      win_col_d   = win_hit ? rd_col_q : win_col_q;
      win_row_d   = win_hit ? rd_row_q : win_row_q;
      done_d      = (state_q == DONE);
      cfg_err_d   = (state_q == DONE) && err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         drain_cnt_q <= '0;
         err_q       <= 1'b0;
         ifm_read_q  <= 1'b0;
         rd_col_q    <= '0;
         rd_row_q    <= '0;
         load_cnt_q  <= '0;
         win_valid_q <= 1'b0;
         win_col_q   <= '0;
         win_row_q   <= '0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         err_q       <= err_d;
         ifm_read_q  <= ifm_read_d;
         rd_col_q    <= rd_col_d;
         rd_row_q    <= rd_row_d;
         load_cnt_q  <= load_cnt_d;
         win_valid_q <= win_valid_d;
         win_col_q   <= win_col_d;
         win_row_q   <= win_row_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign bus.mem_rd_en = mem_rd_en;
   assign bus.mem_addr  = addr;
   assign bus.ifm_read  = ifm_read_q;
   assign bus.win_valid = win_valid_q;
   assign bus.win_col   = win_col_q;
   assign bus.win_row   = win_row_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.cfg_err   = cfg_err_q;

endmodule
